// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: op codes, B-source select codes and datapath defaults.
// Imported by the ALU and by the ID/EX issue stage so both agree on encodings.
package alu_defs;

    localparam int WIDTH_DEF = 32;
    localparam int RA_W_DEF  = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SRA = 3'b101;

    localparam logic [1:0] BSEL_RT    = 2'b00;
    localparam logic [1:0] BSEL_IMM   = 2'b01;
    localparam logic [1:0] BSEL_SHAMT = 2'b10;
    localparam logic [1:0] BSEL_RSVD  = 2'b11;

    // Codes 110/111 have no ALU operation behind them.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op != 3'b110) && (op != 3'b111);
    endfunction

endpackage

// File: rtl/id_ex_alu_issue_fwd_sel.sv
// Operand forwarding mux for one EX source operand.
// Register 0 reads as zero and is never forwarded; MEM beats WB when both match.
module fwd_sel
    import alu_defs::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int RA_W   = RA_W_DEF,
    parameter int FWD_EN = 1
) (
    input  logic [RA_W-1:0]  addr,
    input  logic [WIDTH-1:0] reg_val,
    input  logic             mem_rw,
    input  logic [RA_W-1:0]  mem_rd,
    input  logic [WIDTH-1:0] mem_res,
    input  logic             wb_rw,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic [WIDTH-1:0] wb_res,
    output logic [WIDTH-1:0] fwd_val,
    output logic             hit
);

    // Pick the youngest producer of addr, falling back to the captured value.
    always_comb begin
        fwd_val = reg_val;
        hit     = 1'b0;
        if (addr == '0) begin
            fwd_val = '0;
        end else if (FWD_EN != 0) begin
            if (mem_rw && (mem_rd == addr)) begin
                fwd_val = mem_res;
                hit     = 1'b1;
            end else if (wb_rw && (wb_rd == addr)) begin
                fwd_val = wb_res;
                hit     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline register and ALU operand issue.
// Captures decoded operands, resolves MEM/WB forwarding, selects the B source
// and drives the ALU. Supports stall (hold with forward refresh), flush
// (bubble) and drops illegal op codes with a one-cycle illegal_op pulse.
module id_ex_alu_issue
    import alu_defs::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int RA_W   = RA_W_DEF,
    parameter int FWD_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_rs_val,
    input  logic [WIDTH-1:0] id_rt_val,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic [RA_W-1:0]  id_rd,
    input  logic [2:0]       id_alu_op,
    input  logic [1:0]       id_b_sel,
    input  logic             id_reg_write,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_rw,
    input  logic [RA_W-1:0]  mem_rd,
    input  logic [WIDTH-1:0] mem_res,
    input  logic             wb_rw,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic [WIDTH-1:0] wb_res,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             ex_valid,
    output logic [RA_W-1:0]  ex_rd,
    output logic             ex_reg_write,
    output logic [WIDTH-1:0] ex_store_val,
    output logic             illegal_op
);

    // EX-stage state
    logic             ex_valid_reg;
    logic [RA_W-1:0]  ex_rd_reg;
    logic             ex_reg_write_reg;
    logic [2:0]       alu_op_reg;
    logic [1:0]       b_sel_reg;
    logic [RA_W-1:0]  rs_addr_reg;
    logic [RA_W-1:0]  rt_addr_reg;
    logic [WIDTH-1:0] rs_val_reg;
    logic [WIDTH-1:0] rt_val_reg;
    logic [WIDTH-1:0] imm_reg;
    logic             illegal_reg;

    // Operand 0 = rs (feeds A), operand 1 = rt (feeds B and store data)
    logic [RA_W-1:0]  src_addr [2];
    logic [WIDTH-1:0] src_val  [2];
    logic [WIDTH-1:0] fwd_val  [2];
    logic             fwd_hit  [2];

    logic             id_op_legal;
    logic [WIDTH-1:0] shamt_ext;

    assign src_addr[0] = rs_addr_reg;
    assign src_addr[1] = rt_addr_reg;
    assign src_val[0]  = rs_val_reg;
    assign src_val[1]  = rt_val_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_sel #(
                .WIDTH  (WIDTH),
                .RA_W   (RA_W),
                .FWD_EN (FWD_EN)
            ) u_fwd_sel (
                .addr    (src_addr[gi]),
                .reg_val (src_val[gi]),
                .mem_rw  (mem_rw),
                .mem_rd  (mem_rd),
                .mem_res (mem_res),
                .wb_rw   (wb_rw),
                .wb_rd   (wb_rd),
                .wb_res  (wb_res),
                .fwd_val (fwd_val[gi]),
                .hit     (fwd_hit[gi])
            );
        end
    endgenerate

    assign id_op_legal = op_is_legal(id_alu_op);
    assign shamt_ext   = {{(WIDTH-5){1'b0}}, imm_reg[10:6]};

    // Pipeline register: reset > flush > stall > load; illegal ops load a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_reg     <= 1'b0;
            ex_rd_reg        <= '0;
            ex_reg_write_reg <= 1'b0;
            alu_op_reg       <= ALU_ADD;
            b_sel_reg        <= BSEL_RT;
            rs_addr_reg      <= '0;
            rt_addr_reg      <= '0;
            rs_val_reg       <= '0;
            rt_val_reg       <= '0;
            imm_reg          <= '0;
            illegal_reg      <= 1'b0;
        end else if (flush || (!stall && id_valid && !id_op_legal)) begin
            ex_valid_reg     <= 1'b0;
            ex_rd_reg        <= '0;
            ex_reg_write_reg <= 1'b0;
            alu_op_reg       <= ALU_ADD;
            b_sel_reg        <= BSEL_RT;
            rs_addr_reg      <= '0;
            rt_addr_reg      <= '0;
            rs_val_reg       <= '0;
            rt_val_reg       <= '0;
            imm_reg          <= '0;
            // Only a dropped load reports an illegal op; a flush never does.
            illegal_reg      <= !flush;
        end else if (stall) begin
            // Fold a live forward into the held operand so it outlasts the producer.
            if (fwd_hit[0]) begin
                rs_val_reg <= fwd_val[0];
            end
            if (fwd_hit[1]) begin
                rt_val_reg <= fwd_val[1];
            end
            illegal_reg <= 1'b0;
        end else begin
            ex_valid_reg     <= id_valid;
            ex_rd_reg        <= id_valid ? id_rd : '0;
            ex_reg_write_reg <= id_valid && id_reg_write;
            // A non-valid slot may carry junk op bits; keep the ALU on a defined op.
            alu_op_reg       <= id_op_legal ? id_alu_op : ALU_ADD;
            b_sel_reg        <= id_b_sel;
            rs_addr_reg      <= id_rs;
            rt_addr_reg      <= id_rt;
            rs_val_reg       <= id_rs_val;
            rt_val_reg       <= id_rt_val;
            imm_reg          <= id_imm;
            illegal_reg      <= 1'b0;
        end
    end

    // B operand source select; reserved code behaves as rt.
    always_comb begin
        alu_b = fwd_val[1];
        case (b_sel_reg)
            BSEL_IMM:   alu_b = imm_reg;
            BSEL_SHAMT: alu_b = shamt_ext;
            default:    alu_b = fwd_val[1];
        endcase
    end

    assign alu_a        = fwd_val[0];
    assign alu_op       = alu_op_reg;
    assign ex_valid     = ex_valid_reg;
    assign ex_rd        = ex_rd_reg;
    assign ex_reg_write = ex_reg_write_reg;
    assign ex_store_val = fwd_val[1];
    assign illegal_op   = illegal_reg;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Bench for id_ex_alu_issue: behavioural EX-slot model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_id_ex_alu_issue;
    import alu_defs::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_rs_val = '0, id_rt_val = '0, id_imm = '0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic [2:0]  id_alu_op = '0;
    logic [1:0]  id_b_sel = '0;
    logic        id_reg_write = 1'b0;
    logic        stall = 1'b0, flush = 1'b0;
    logic        mem_rw = 1'b0, wb_rw = 1'b0;
    logic [4:0]  mem_rd = '0, wb_rd = '0;
    logic [31:0] mem_res = '0, wb_res = '0;
    logic [31:0] alu_a, alu_b, ex_store_val;
    logic [2:0]  alu_op;
    logic        ex_valid, ex_reg_write, illegal_op;
    logic [4:0]  ex_rd;

    always #5 clk = ~clk;

    id_ex_alu_issue #(.WIDTH(32), .RA_W(5), .FWD_EN(1)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_op(id_alu_op), .id_b_sel(id_b_sel), .id_reg_write(id_reg_write),
        .stall(stall), .flush(flush),
        .mem_rw(mem_rw), .mem_rd(mem_rd), .mem_res(mem_res),
        .wb_rw(wb_rw), .wb_rd(wb_rd), .wb_res(wb_res),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_store_val(ex_store_val), .illegal_op(illegal_op)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the EX slot ----------------
    typedef struct packed {
        bit          valid;
        logic [4:0]  rd;
        bit          rw;
        logic [2:0]  op;
        logic [1:0]  bsel;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rsv;
        logic [31:0] rtv;
        logic [31:0] imm;
    } ex_t;

    ex_t m;
    bit  m_ill;

    function automatic logic [31:0] mfwd(input logic [4:0] a, input logic [31:0] v);
        if (a == 5'd0) return 32'd0;
        if (mem_rw && mem_rd == a) return mem_res;
        if (wb_rw && wb_rd == a) return wb_res;
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m <= '0;
            m_ill <= 1'b0;
        end else if (flush) begin
            m <= '0;
            m_ill <= 1'b0;
        end else if (stall) begin
            m.rsv <= mfwd(m.rs, m.rsv);
            m.rtv <= mfwd(m.rt, m.rtv);
            m_ill <= 1'b0;
        end else if (id_valid && id_alu_op > 3'd5) begin
            m <= '0;
            m_ill <= 1'b1;
        end else begin
            m.valid <= id_valid;
            m.rd    <= id_valid ? id_rd : 5'd0;
            m.rw    <= id_valid && id_reg_write;
            m.op    <= (id_alu_op > 3'd5) ? 3'd0 : id_alu_op;
            m.bsel  <= id_b_sel;
            m.rs    <= id_rs;
            m.rt    <= id_rt;
            m.rsv   <= id_rs_val;
            m.rtv   <= id_rt_val;
            m.imm   <= id_imm;
            m_ill   <= 1'b0;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (reset === 1'b1 && chk_en) begin
            logic [31:0] a_e, rt_e, b_e;
            a_e  = mfwd(m.rs, m.rsv);
            rt_e = mfwd(m.rt, m.rtv);
            if (m.bsel == 2'b01)      b_e = m.imm;
            else if (m.bsel == 2'b10) b_e = (m.imm >> 6) & 32'h1F;
            else                      b_e = rt_e;
            check("mdl_alu_a", alu_a, a_e);
            check("mdl_alu_b", alu_b, b_e);
            check("mdl_alu_op", {29'd0, alu_op}, {29'd0, m.op});
            check("mdl_ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
            check("mdl_ex_rd", {27'd0, ex_rd}, {27'd0, m.rd});
            check("mdl_ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m.rw});
            check("mdl_store_val", ex_store_val, rt_e);
            check("mdl_illegal_op", {31'd0, illegal_op}, {31'd0, m_ill});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic id_set(input bit v, input logic [4:0] rs, input logic [31:0] rsv,
                          input logic [4:0] rt, input logic [31:0] rtv, input logic [4:0] rd,
                          input logic [31:0] imm, input logic [2:0] op, input logic [1:0] bsel,
                          input bit rw);
        id_valid = v; id_rs = rs; id_rs_val = rsv; id_rt = rt; id_rt_val = rtv;
        id_rd = rd; id_imm = imm; id_alu_op = op; id_b_sel = bsel; id_reg_write = rw;
    endtask

    // Non-valid slot with junk rd/reg_write that must not leak into EX
    task automatic id_idle();
        id_set(1'b0, 5'd12, 32'h1234, 5'd13, 32'h5678, 5'd31, 32'h0, ALU_ADD, BSEL_RT, 1'b1);
    endtask

    task automatic fwd_clear();
        mem_rw = 1'b0; mem_rd = '0; mem_res = '0;
        wb_rw = 1'b0; wb_rd = '0; wb_res = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        chk_en = 1'b1;

        // 1: traffic, then asynchronous reset mid-cycle with a live forward
        id_set(1, 5'd5, 32'd7, 5'd6, 32'd3, 5'd1, 32'h0, ALU_ADD, BSEL_RT, 1);
        tick();
        id_set(1, 5'd2, 32'd100, 5'd3, 32'd200, 5'd4, 32'h0, ALU_SUB, BSEL_RT, 1);
        mem_rw = 1; mem_rd = 5'd5; mem_res = 32'hBAD;
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_op", {29'd0, alu_op}, 32'd0);
        check("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
        check("rst_ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
        check("rst_illegal_op", {31'd0, illegal_op}, 32'd0);
        check("rst_store_val", ex_store_val, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        fwd_clear();
        id_set(1, 5'd5, 32'd7, 5'd6, 32'd3, 5'd1, 32'h0, ALU_ADD, BSEL_RT, 1);
        tick();
        id_idle();
        @(negedge clk);
        check("t1_alu_a", alu_a, 32'd7);
        check("t1_alu_b", alu_b, 32'd3);
        check("t1_alu_op", {29'd0, alu_op}, 32'd0);
        check("t1_ex_valid", {31'd0, ex_valid}, 32'd1);

        // 2: MEM beats WB, WB alone, register 0 never forwarded
        id_set(1, 5'd8, 32'h99, 5'd0, 32'h0, 5'd2, 32'h0, ALU_OR, BSEL_IMM, 1);
        tick();
        stall = 1;
        id_idle();
        mem_rw = 1; mem_rd = 5'd8; mem_res = 32'h11;
        wb_rw = 1; wb_rd = 5'd8; wb_res = 32'h22;
        @(negedge clk);
        check("t2_mem_wins", alu_a, 32'h11);
        mem_rw = 0;
        #1;
        check("t2_wb_only", alu_a, 32'h22);
        tick();
        stall = 0;
        id_set(1, 5'd0, 32'h55, 5'd0, 32'h66, 5'd2, 32'h0, ALU_ADD, BSEL_RT, 1);
        mem_rw = 1; mem_rd = 5'd0; mem_res = 32'h33;
        wb_rw = 1; wb_rd = 5'd0; wb_res = 32'h44;
        tick();
        id_idle();
        @(negedge clk);
        check("t2_r0_a", alu_a, 32'd0);
        check("t2_r0_b", alu_b, 32'd0);
        fwd_clear();

        // 3: 3-cycle stall, WB forward to rt only during the first cycle
        id_set(1, 5'd1, 32'd5, 5'd9, 32'd1, 5'd3, 32'h0, ALU_ADD, BSEL_RT, 1);
        tick();
        stall = 1;
        id_idle();
        wb_rw = 1; wb_rd = 5'd9; wb_res = 32'hDEAD;
        @(negedge clk);
        check("t3_c1_alu_b", alu_b, 32'hDEAD);
        tick();
        fwd_clear();
        @(negedge clk);
        check("t3_c2_alu_b", alu_b, 32'hDEAD);
        tick();
        @(negedge clk);
        check("t3_c3_alu_b", alu_b, 32'hDEAD);
        check("t3_held_valid", {31'd0, ex_valid}, 32'd1);
        tick();
        stall = 0;
        @(negedge clk);
        check("t3_post_alu_b", alu_b, 32'hDEAD);
        check("t3_post_store", ex_store_val, 32'hDEAD);

        // 4: shamt zero-extended, then raw immediate
        id_set(1, 5'd1, 32'd5, 5'd2, 32'd6, 5'd4, 32'h7C0, ALU_SRA, BSEL_SHAMT, 1);
        tick();
        id_set(1, 5'd1, 32'd5, 5'd2, 32'd6, 5'd4, 32'h7C0, ALU_SRL, BSEL_IMM, 1);
        @(negedge clk);
        check("t4_shamt", alu_b, 32'h1F);
        check("t4_op_sra", {29'd0, alu_op}, 32'd5);
        tick();
        id_idle();
        @(negedge clk);
        check("t4_imm", alu_b, 32'h7C0);
        check("t4_op_srl", {29'd0, alu_op}, 32'd4);

        // 5: illegal op dropped with a single-cycle pulse
        id_set(1, 5'd3, 32'd1, 5'd4, 32'd2, 5'd5, 32'h0, 3'b110, BSEL_RT, 1);
        tick();
        id_idle();
        @(negedge clk);
        check("t5_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("t5_reg_write", {31'd0, ex_reg_write}, 32'd0);
        check("t5_ex_rd", {27'd0, ex_rd}, 32'd0);
        check("t5_pulse", {31'd0, illegal_op}, 32'd1);
        tick();
        @(negedge clk);
        check("t5_pulse_end", {31'd0, illegal_op}, 32'd0);
        check("t5_idle_rd", {27'd0, ex_rd}, 32'd0);
        // Illegal code presented during a stall is ignored
        id_set(1, 5'd3, 32'd1, 5'd4, 32'd2, 5'd5, 32'h0, ALU_AND, BSEL_RT, 1);
        tick();
        stall = 1;
        id_set(1, 5'd3, 32'd1, 5'd4, 32'd2, 5'd6, 32'h0, 3'b111, BSEL_RT, 1);
        tick();
        stall = 0;
        id_idle();
        @(negedge clk);
        check("t5_stall_nopulse", {31'd0, illegal_op}, 32'd0);
        check("t5_stall_held_rd", {27'd0, ex_rd}, 32'd5);

        // 6: flush wins over stall, then a normal load
        id_set(1, 5'd1, 32'd5, 5'd2, 32'd6, 5'd6, 32'h0, ALU_AND, BSEL_RT, 1);
        tick();
        stall = 1; flush = 1;
        id_set(1, 5'd1, 32'd5, 5'd2, 32'd6, 5'd9, 32'h0, ALU_SUB, BSEL_RT, 1);
        tick();
        stall = 0; flush = 0;
        id_set(1, 5'd1, 32'd5, 5'd2, 32'd6, 5'd7, 32'h0, ALU_OR, BSEL_RT, 1);
        @(negedge clk);
        check("t6_bubble_valid", {31'd0, ex_valid}, 32'd0);
        check("t6_bubble_rd", {27'd0, ex_rd}, 32'd0);
        check("t6_bubble_rw", {31'd0, ex_reg_write}, 32'd0);
        tick();
        id_idle();
        @(negedge clk);
        check("t6_load_valid", {31'd0, ex_valid}, 32'd1);
        check("t6_load_rd", {27'd0, ex_rd}, 32'd7);
        check("t6_load_op", {29'd0, alu_op}, 32'd3);

        repeat (3) tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
